// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmitter: FSM state
// encoding, frame constants and the round-robin grant rule.
package uart_tx_arbiter_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned NUM_REQ   = 2;
   localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // Single requester wins outright; on a tie the one that was not served last wins.
   function automatic logic [NUM_REQ-1:0] rr_grant(input logic [NUM_REQ-1:0] valid,
                                                   input logic               last_grant);
      logic [NUM_REQ-1:0] g;
      g = valid;
      if (&valid) begin
         g = last_grant ? NUM_REQ'(1) : NUM_REQ'(2);
      end
      return g;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous restart of the count at 0
//   en         : count while high (frame in progress)
//   bit_end    : strobe in the last cycle of each bit period
module uart_bit_timer #(
   parameter int unsigned CLOCKS_PER_BIT = 5000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic bit_end
);

   localparam int unsigned    CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign bit_end = en && (cnt == LAST);

   // Counter 0..CLOCKS_PER_BIT-1, wrapping at the end of every bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter (8N1) with round-robin arbitration.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid[1:0]       : per-requester byte valid
//   req_data0, req_data1 : bytes offered by requester 0 / 1
//   req_ready[1:0]       : per-requester ready, only in IDLE, at most one high
//   tx                   : registered serial line, idle high
//   busy                 : frame in progress
//   grant_id             : requester of the current or most recent frame
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned CLOCKS_PER_BIT = 5000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [DATA_BITS-1:0] req_data0,
   input  logic [DATA_BITS-1:0] req_data1,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 grant_id
);

   tx_state_e            state;
   logic [DATA_BITS-1:0] shift_q;
   logic [BIT_IDX_W-1:0] bit_idx;
   logic                 last_grant;
   logic [NUM_REQ-1:0]   grant;
   logic                 hs;
   logic                 hs_id;
   logic                 bit_end;

   // Ready is gated by rst_n so nothing is offered while reset is held.
   assign grant     = rr_grant(req_valid, last_grant);
   assign req_ready = (rst_n && (state == IDLE)) ? grant : '0;
   assign hs        = |(req_valid & req_ready);
   assign hs_id     = grant[1];
   assign busy      = (state != IDLE);

   uart_bit_timer #(
      .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
   ) u_bit_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (hs),
      .en     (busy),
      .bit_end(bit_end)
   );

   // Frame FSM; tx is updated together with the state so the line never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tx         <= 1'b1;
         shift_q    <= '0;
         bit_idx    <= '0;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (hs) begin
                  shift_q    <= hs_id ? req_data1 : req_data0;
                  grant_id   <= hs_id;
                  last_grant <= hs_id;
                  bit_idx    <= '0;
                  tx         <= 1'b0;
                  state      <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  bit_idx <= '0;
                  tx      <= shift_q[0];
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift_q <= shift_q >> 1;
                  if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + BIT_IDX_W'(1);
                     tx      <= shift_q[1];
                  end
               end
            end
            STOP: begin
               if (bit_end) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with CLOCKS_PER_BIT=8.
module tb_uart_tx_arbiter;

   localparam int unsigned CPB   = 8;
   localparam int unsigned FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req_valid = 2'b00;
   logic [7:0] req_data0 = 8'h00;
   logic [7:0] req_data1 = 8'h00;
   logic [1:0] req_ready;
   logic       tx;
   logic       busy;
   logic       grant_id;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_cnt = 0;

   uart_tx_arbiter #(.CLOCKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_data0(req_data0),
      .req_data1(req_data1),
      .req_ready(req_ready),
      .tx       (tx),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 50) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // A frame is a 10-bit pattern {1, byte, 0} lasting FRAME cycles; m_cyc is
   // the number of cycles elapsed since the frame started.
   bit         m_busy;
   int         m_cyc;
   logic [7:0] m_byte;
   logic       m_gid;
   logic       m_last;
   logic       m_win;

   // Index of the requester that should win, or -1 when nobody asks.
   function automatic int winner(input logic [1:0] v, input logic last);
      if (v == 2'b00) return -1;
      if (v == 2'b11) return last ? 0 : 1;
      return v[1] ? 1 : 0;
   endfunction

   function automatic logic [1:0] exp_ready();
      int w;
      w = winner(req_valid, m_last);
      if (m_busy || w < 0) return 2'b00;
      return (w == 1) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic exp_tx();
      logic [9:0] frame_bits;
      int         slot;
      if (!m_busy) return 1'b1;
      frame_bits = {1'b1, m_byte, 1'b0};
      slot       = m_cyc / CPB;
      return frame_bits[slot];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_cyc = 0; m_byte = 8'h00; m_gid = 1'b0; m_last = 1'b1;
      end else if (!m_busy) begin
         if (winner(req_valid, m_last) >= 0) begin
            m_win  = (winner(req_valid, m_last) == 1);
            m_busy = 1;
            m_cyc  = 0;
            m_gid  = m_win;
            m_last = m_win;
            m_byte = m_win ? req_data1 : req_data0;
         end
      end else begin
         m_cyc++;
         if (m_cyc == FRAME) m_busy = 0;
      end
   end

   // Cycle-by-cycle comparison and invariants, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("tx", 8'(tx), 8'(exp_tx()));
         check("busy", 8'(busy), 8'(m_busy));
         check("grant_id", 8'(grant_id), 8'(m_gid));
         check("req_ready", 8'(req_ready), 8'(exp_ready()));
         check("ready_both_high", 8'(req_ready == 2'b11), 8'h00);
         check("ready_while_busy", 8'(busy && (req_ready != 2'b00)), 8'h00);
         check("tx_low_idle", 8'(!busy && !tx), 8'h00);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 2 * FRAME) begin tick(1); t++; end
      check("wait_idle", 8'(busy), 8'h00);
   endtask

   // Offer a request, wait for the frame to start, then withdraw it.
   task automatic send(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       output int lat);
      wait_idle();
      req_valid = v; req_data0 = d0; req_data1 = d1;
      lat = 0;
      do begin tick(1); lat++; end while (!busy && lat < 3 * FRAME);
      check("send_busy", 8'(busy), 8'h01);
      req_valid = 2'b00;
   endtask

   // Decode one frame from tx at mid-bit; st is the cycle the start bit appeared.
   task automatic recv(output logic [7:0] b, output logic g, output int st);
      int t = 0;
      b = 8'h00; g = 1'b0; st = cyc_cnt;
      while (tx !== 1'b0 && t < 4 * FRAME) begin tick(1); t++; end
      check("frame_start", 8'(tx), 8'h00);
      if (tx !== 1'b0) return;
      st = cyc_cnt;
      g  = grant_id;
      tick(CPB / 2);
      check("start_bit", 8'(tx), 8'h00);
      for (int i = 0; i < 8; i++) begin
         tick(CPB);
         b[i] = tx;
      end
      tick(CPB);
      check("stop_bit", 8'(tx), 8'h01);
   endtask

   typedef struct {
      logic [1:0] valid;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] exp_byte;
      logic       exp_gid;
   } vec_t;

   vec_t       vecs[8];
   logic [7:0] rb;
   logic       rg;
   int         st, prev_st, lat;
   logic [7:0] s2_bytes[4];

   initial begin
      // Requester order after reset: last_grant=1, so requester 0 wins the first tie.
      vecs[0] = '{2'b01, 8'h55, 8'h00, 8'h55, 1'b0};
      vecs[1] = '{2'b11, 8'hA5, 8'h3C, 8'h3C, 1'b1};
      vecs[2] = '{2'b11, 8'h11, 8'h22, 8'h11, 1'b0};
      vecs[3] = '{2'b10, 8'h00, 8'hFF, 8'hFF, 1'b1};
      vecs[4] = '{2'b10, 8'h00, 8'h81, 8'h81, 1'b1};
      vecs[5] = '{2'b11, 8'h7E, 8'h00, 8'h7E, 1'b0};
      vecs[6] = '{2'b01, 8'hC3, 8'hAA, 8'hC3, 1'b0};
      vecs[7] = '{2'b11, 8'h5A, 8'h96, 8'h96, 1'b1};
      s2_bytes[0] = 8'hA5; s2_bytes[1] = 8'h3C; s2_bytes[2] = 8'hA5; s2_bytes[3] = 8'h3C;

      // Reset state, with requests pending to prove ready stays low.
      rst_n = 1'b0; req_valid = 2'b11;
      tick(3);
      check("rst_tx", 8'(tx), 8'h01);
      check("rst_busy", 8'(busy), 8'h00);
      check("rst_ready", 8'(req_ready), 8'h00);
      check("rst_grant_id", 8'(grant_id), 8'h00);
      req_valid = 2'b00;
      rst_n = 1'b1;

      // Table-driven frames; the first one also checks first-edge handshake.
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].valid, vecs[i].d0, vecs[i].d1, lat);
         if (i == 0) check("first_hs_latency", 8'(lat), 8'h01);
         recv(rb, rg, st);
         check("vec_byte", rb, vecs[i].exp_byte);
         check("vec_gid", 8'(rg), 8'(vecs[i].exp_gid));
      end

      // Both valid held: strict alternation with one idle cycle between frames.
      wait_idle();
      req_valid = 2'b11; req_data0 = 8'hA5; req_data1 = 8'h3C;
      prev_st = 0;
      for (int i = 0; i < 4; i++) begin
         recv(rb, rg, st);
         check("rr_byte", rb, s2_bytes[i]);
         check("rr_gid", 8'(rg), 8'(i % 2));
         if (i > 0) check("rr_spacing", 8'(st - prev_st), 8'(FRAME + 1));
         prev_st = st;
      end

      // Only requester 1 valid: back-to-back frames to requester 1.
      req_valid = 2'b10; req_data1 = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         recv(rb, rg, st);
         check("solo1_byte", rb, 8'hFF);
         check("solo1_gid", 8'(rg), 8'h01);
         check("solo1_spacing", 8'(st - prev_st), 8'(FRAME + 1));
         prev_st = st;
      end
      req_valid = 2'b00;

      // Short pulse while busy is ignored and leaves last_grant at 1.
      send(2'b10, 8'h00, 8'h99, lat);
      tick(20);
      req_valid = 2'b01; req_data0 = 8'h44;
      tick(1);
      req_valid = 2'b00;
      wait_idle();
      tick(3 * FRAME);
      check("no_extra_frame", 8'(busy), 8'h00);
      send(2'b11, 8'h12, 8'h34, lat);
      recv(rb, rg, st);
      check("pulse_tie_byte", rb, 8'h12);
      check("pulse_tie_gid", 8'(rg), 8'h00);

      // Reset 37 cycles into a 0x00 frame, then a clean 0x81 frame.
      send(2'b01, 8'h00, 8'h00, lat);
      tick(37);
      rst_n = 1'b0; req_valid = 2'b01; req_data0 = 8'h81;
      #1;
      check("midrst_tx", 8'(tx), 8'h01);
      check("midrst_busy", 8'(busy), 8'h00);
      check("midrst_ready", 8'(req_ready), 8'h00);
      tick(2);
      check("midrst_grant_id", 8'(grant_id), 8'h00);
      rst_n = 1'b1;
      send(2'b01, 8'h81, 8'h00, lat);
      check("post_rst_latency", 8'(lat), 8'h01);
      recv(rb, rg, st);
      check("post_rst_byte", rb, 8'h81);
      check("post_rst_gid", 8'(rg), 8'h00);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            req_valid = 2'($urandom_range(0, 3));
            req_data0 = 8'($urandom);
            req_data1 = 8'($urandom);
         end
         tick(1);
      end
      req_valid = 2'b00;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLOCKS_PER_BIT, default 5000, is the clock cycles per UART bit period; legal range is 2 or more.
REQ-002 Signal clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 Signal rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-004 Signal req_valid, input, 2 bits, is one valid per requester (index 0, 1).
REQ-005 Signal req_data0, input, 8 bits, is the byte offered by requester 0.
REQ-006 Signal req_data1, input, 8 bits, is the byte offered by requester 1.
REQ-007 Signal req_ready, output, 2 bits, is one ready per requester; at most one bit is high in any cycle.
REQ-008 Signal tx, output, 1 bit, is the serial line; idle is high.
REQ-009 Signal busy, output, 1 bit, is high while a frame is in progress.
REQ-010 Signal grant_id, output, 1 bit, is the index of the requester whose frame is in progress or was sent last.

Function
REQ-011 FSM states: IDLE, START, DATA, STOP.
REQ-012 req_ready[i] = (state==IDLE) and grant[i], combinational; a handshake occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-013 Grant rule: if only one valid is high, that requester is granted; if both are high, the requester other than last_grant is granted (round-robin).
REQ-014 On a handshake: the selected byte is latched into the shift register, grant_id and last_grant take the granted index, the state goes IDLE->START, and the bit counter clears to 0.
REQ-015 Bit timing: an internal counter runs 0..CLOCKS_PER_BIT-1 while busy; bit_end occurs when the counter equals CLOCKS_PER_BIT-1, after which the counter wraps to 0.
REQ-016 The counter restarts at frame start, so the start bit is exactly CLOCKS_PER_BIT cycles and is never truncated.
REQ-017 In START, tx=0; on bit_end the state goes to DATA with bit index 0.
REQ-018 In DATA, tx = shift register bit 0, so data goes LSB first; on bit_end the register shifts right; after the 8th bit_end the state goes to STOP.
REQ-019 In STOP, tx=1; on bit_end the state goes to IDLE.
REQ-020 tx is registered: it falls on the edge after the handshake and stays glitch-free.
REQ-021 Frame length is exactly 10*CLOCKS_PER_BIT cycles, from tx falling to state IDLE.
REQ-022 Minimum inter-frame spacing: after STOP ends, one IDLE cycle follows, in which the handshake occurs; tx stays high during it.
REQ-023 busy = (state != IDLE).
REQ-024 req_valid changes during a frame have no effect.
REQ-025 A valid that is withdrawn before its handshake is not latched and does not change last_grant.
REQ-026 Simultaneous valids arriving in the cycle STOP ends are arbitrated in the following IDLE cycle.

Reset
REQ-027 While rst_n is low: state=IDLE, tx=1, busy=0, req_ready=0, grant_id=0, last_grant=1 (so requester 0 wins the first tie), counter=0, shift register=0.
REQ-028 Reset mid-frame abandons the frame immediately; tx returns to 1 asynchronously and no partial frame resumes after release.
REQ-029 The first handshake is possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package holds the FSM state encoding, the constant DATA_BITS=8, and the constant NUM_REQ=2.
REQ-031 One sub-module, uart_bit_timer, holds the bit-period counter with a synchronous clear and a bit_end strobe output; it is parameterised by CLOCKS_PER_BIT.
REQ-032 Arbitration, the FSM and the shifter stay in uart_tx_arbiter.
REQ-033 Total size is about 150-250 lines of RTL.

Verification (bench uses CLOCKS_PER_BIT=8)
REQ-034 Scenario 1: after reset, req_valid=01, req_data0=0x55 -> req_ready=01 for one cycle; tx is 0 for 8 cycles, then 1,0,1,0,1,0,1,0 at 8 cycles each, then 1 for 8; busy is high for 80 cycles.
REQ-035 Scenario 2: req_valid=11 held, data0=0xA5, data1=0x3C -> frames go out in order 0xA5 (grant_id 0), 0x3C (grant_id 1), 0xA5, 0x3C; each frame is 80 cycles with a gap of 1 idle cycle.
REQ-036 Scenario 3: req_valid=10 only, data1=0xFF, held for two frames -> both frames go to requester 1 back-to-back; the tx low time per frame is exactly 8 cycles.
REQ-037 Scenario 4: rst_n pulsed low at cycle 37 of a frame of 0x00 -> tx=1 within the same cycle, busy=0; after release, a new req_valid=01 with 0x81 transmits a full, correct frame.
REQ-038 Scenario 5: req_valid=01 asserted for 1 cycle while busy, then dropped -> no extra frame is sent and last_grant is unchanged.
REQ-039 Scenario 6 (checker over all tests): req_ready is never 11 and is never high while busy; tx is never low while in IDLE.
